// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel window path.
// Holds the scheduler state encoding and tap geometry.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FETCH = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam int TAPS = 9;
  localparam logic [3:0] TAP_LAST = 4'(TAPS - 1);

  // Address jump from the last tap of one window row to the first of the next.
  function automatic int row_step(input int img_w);
    return img_w - 2;
  endfunction

endpackage

// File: rtl/sobel_addr_gen.sv
// RAM read address sequencer for 3x3 windows.
// Walks taps within a window, then windows in raster order.
module sobel_addr_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 720,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_i,
  output logic [ADDR_W-1:0] raddr_o,
  output logic [3:0]        tap_o,
  output logic              last_win_o
);

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] WIN_LAST =
    ADDR_W'((IMG_W - 2) * (IMG_H - 2) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(row_step(IMG_W));

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] win_q, win_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [3:0]        tap_q, tap_d;
  logic              last_win;

  assign last_win = (win_q == WIN_LAST) &&
                    (row_q == ROW_LAST) &&
                    (col_q == COL_LAST);

  always_comb begin
    base_d  = base_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    raddr_d = raddr_q;
    tap_d   = tap_q;
    if (issue_i) begin
      if (tap_q == TAP_LAST) begin
        tap_d = 4'd0;
        if (last_win) begin
          base_d = '0;
          col_d  = '0;
          row_d  = '0;
          win_d  = '0;
        end else if (col_q == COL_LAST) begin
          base_d = base_q + ADDR_W'(3);
          col_d  = '0;
          row_d  = row_q + ADDR_W'(1);
          win_d  = win_q + ADDR_W'(1);
        end else begin
          base_d = base_q + ADDR_W'(1);
          col_d  = col_q + ADDR_W'(1);
          win_d  = win_q + ADDR_W'(1);
        end
        raddr_d = base_d;
      end else begin
        tap_d = tap_q + 4'd1;
        if (tap_q == 4'd2 || tap_q == 4'd5) begin
          raddr_d = raddr_q + ROW_STEP;
        end else begin
          raddr_d = raddr_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      raddr_q <= '0;
      tap_q   <= 4'd0;
    end else begin
      base_q  <= base_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      raddr_q <= raddr_d;
      tap_q   <= tap_d;
    end
  end

  assign raddr_o    = raddr_q;
  assign tap_o      = tap_q;
  assign last_win_o = last_win;

endmodule

// File: rtl/sobel_window_scheduler.sv
// Loads one frame into the shared RAM, then streams every 3x3 window
// to the convolver as nine consecutive taps.
module sobel_window_scheduler
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 720,
  parameter int IMG_H  = 120,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [PIX_W-1:0]  mem_rdata,
  input  logic              conv_ready,
  output logic              tap_valid,
  output logic [PIX_W-1:0]  tap_data,
  output logic [3:0]        tap_idx,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_W * IMG_H - 1);

  state_e            state_q;
  logic              pix_ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [PIX_W-1:0]  wdata_q;
  logic [ADDR_W-1:0] wcount_q;
  logic              tap_valid_q;
  logic [3:0]        tap_idx_q;
  logic              frame_done_q;
  logic              busy_q;

  logic              accept;
  logic              last_pix;
  logic              issue;
  logic              final_tap;
  logic [3:0]        tap_cnt;
  logic              last_win;

  assign accept   = pix_valid & pix_ready_q;
  assign last_pix = accept && (wcount_q == PIX_LAST);

  // The final pixel's write lands in the first FETCH cycle; hold reads off
  // until it retires so the RAM never sees a read and write together.
  assign issue = (state_q == FETCH) && !we_q &&
                 ((tap_cnt != 4'd0) || conv_ready);
  assign final_tap = issue && (tap_cnt == TAP_LAST) && last_win;

  sobel_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .issue_i    (issue),
    .raddr_o    (mem_raddr),
    .tap_o      (tap_cnt),
    .last_win_o (last_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pix_ready_q  <= 1'b1;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wcount_q     <= '0;
      tap_valid_q  <= 1'b0;
      tap_idx_q    <= 4'd0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      we_q         <= accept;
      tap_valid_q  <= issue;
      tap_idx_q    <= tap_cnt;
      frame_done_q <= final_tap;
      if (accept) begin
        waddr_q  <= wcount_q;
        wdata_q  <= pix_in;
        wcount_q <= last_pix ? '0 : wcount_q + ADDR_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          if (last_pix) begin
            state_q     <= FETCH;
            pix_ready_q <= 1'b0;
          end
        end
        FETCH: begin
          if (final_tap) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          pix_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign pix_ready  = pix_ready_q;
  assign mem_we     = we_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign tap_valid  = tap_valid_q;
  assign tap_idx    = tap_idx_q;
  assign tap_data   = tap_valid_q ? mem_rdata : '0;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sobel_window_scheduler.sv
// Scoreboard bench for sobel_window_scheduler on a 5x5 frame
// with a one-cycle-latency RAM model.
module tb_sobel_window_scheduler;

  localparam int W    = 5;
  localparam int H    = 5;
  localparam int PW   = 8;
  localparam int AW   = 5;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 2) * (H - 2);
  localparam int NTAP = NWIN * 9;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    idx;
    logic [PW-1:0] data;
    logic          done;
  } tap_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [PW-1:0] mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [PW-1:0] mem_rdata;
  logic          conv_ready;
  logic          tap_valid;
  logic [PW-1:0] tap_data;
  logic [3:0]    tap_idx;
  logic          frame_done;
  logic          busy;

  sobel_window_scheduler #(
    .IMG_W  (W),
    .IMG_H  (H),
    .PIX_W  (PW),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .conv_ready (conv_ready),
    .tap_valid  (tap_valid),
    .tap_data   (tap_data),
    .tap_idx    (tap_idx),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    mem_rdata <= ram[mem_raddr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int tv_count = 0;
  int done_count = 0;
  int wr_count = 0;
  int tv_cyc[$];
  logic [PW-1:0] last_data;
  logic [AW-1:0] prev_raddr = '0;
  logic [PW-1:0] pix_m [0:NPIX-1];
  wr_t  wq[$];
  tap_t tq[$];

  task automatic clr_stats();
    tv_count = 0;
    done_count = 0;
    wr_count = 0;
    tv_cyc.delete();
  endtask

  task automatic mon_step();
    wr_t w;
    tap_t t;
    if (mem_we) begin
      wr_count++;
      n_tests++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected addr=%0d data=%0d",
                 mem_waddr, mem_wdata);
      end else begin
        w = wq.pop_front();
        if (mem_waddr !== w.addr || mem_wdata !== w.data) begin
          n_fail++;
          $display("FAIL write got a=%0d d=%0d want a=%0d d=%0d",
                   mem_waddr, mem_wdata, w.addr, w.data);
        end
      end
    end
    if (tap_valid) begin
      tv_count++;
      tv_cyc.push_back(cyc);
      last_data = tap_data;
      if (frame_done) done_count++;
      n_tests++;
      if (tq.size() == 0) begin
        n_fail++;
        $display("FAIL tap_unexpected idx=%0d data=%0d",
                 tap_idx, tap_data);
      end else begin
        t = tq.pop_front();
        if (prev_raddr !== t.addr || tap_idx !== t.idx ||
            tap_data !== t.data || frame_done !== t.done) begin
          n_fail++;
          $display("FAIL tap got a=%0d i=%0d d=%0d fd=%0b want a=%0d i=%0d d=%0d fd=%0b",
                   prev_raddr, tap_idx, tap_data, frame_done,
                   t.addr, t.idx, t.data, t.done);
        end
      end
    end else if (frame_done !== 1'b0) begin
      done_count++;
      n_tests++;
      n_fail++;
      $display("FAIL frame_done_without_tap got=%0b want=0", frame_done);
    end
    prev_raddr = mem_raddr;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rst) mon_step();
  endtask

  task automatic push_taps();
    tap_t t;
    int a;
    for (int w = 0; w < NWIN; w++) begin
      for (int k = 0; k < 9; k++) begin
        a = ((w / (W - 2)) + k / 3) * W + (w % (W - 2)) + k % 3;
        t.addr = AW'(a);
        t.idx  = 4'(k);
        t.data = pix_m[a];
        t.done = (w == NWIN - 1) && (k == 8);
        tq.push_back(t);
      end
    end
  endtask

  task automatic feed_frame(input bit toggle, input bit chk_first);
    int  i = 0;
    int  guard = 0;
    bit  ph = 1'b0;
    wr_t w;
    for (int k = 0; k < NPIX; k++) pix_m[k] = PW'($urandom_range(0, 255));
    while (i < NPIX && guard < 3000) begin
      guard++;
      pix_in = pix_m[i];
      pix_valid = !(toggle && ph);
      if (pix_valid && pix_ready) begin
        if (chk_first && i == 0) begin
          n_tests++;
          if (busy !== 1'b0 || done_count != 1 || wr_count != NPIX) begin
            n_fail++;
            $display("FAIL first_accept busy=%0b done=%0d writes=%0d want 0 1 %0d",
                     busy, done_count, wr_count, NPIX);
          end
        end
        w.addr = AW'(i);
        w.data = pix_m[i];
        wq.push_back(w);
        i++;
      end
      ph = ~ph;
      tick();
    end
    pix_valid = 1'b0;
    if (i < NPIX) begin
      n_tests++;
      n_fail++;
      $display("FAIL feed_timeout got=%0d want=%0d", i, NPIX);
    end
    push_taps();
  endtask

  task automatic wait_done(input int want, input int budget);
    int g = 0;
    while (done_count < want && g < budget) begin
      tick();
      g++;
    end
    n_tests++;
    if (done_count != want || tq.size() != 0) begin
      n_fail++;
      $display("FAIL frame_done_wait got=%0d left=%0d want=%0d left=0",
               done_count, tq.size(), want);
    end
  endtask

  task automatic wait_taps(input int n, input int budget);
    int g = 0;
    while (tv_count < n && g < budget) begin
      tick();
      g++;
    end
    n_tests++;
    if (tv_count != n) begin
      n_fail++;
      $display("FAIL tap_wait got=%0d want=%0d", tv_count, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_in = '0;
    conv_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({pix_ready, mem_we, tap_valid, frame_done, busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b want=10000",
               {pix_ready, mem_we, tap_valid, frame_done, busy});
    end
    n_tests++;
    if ({mem_waddr, mem_wdata, mem_raddr, tap_data, tap_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got wa=%0d wd=%0d ra=%0d td=%0d ti=%0d want 0",
               mem_waddr, mem_wdata, mem_raddr, tap_data, tap_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    clr_stats();
    feed_frame(1'b0, 1'b0);
    n_tests++;
    if (pix_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_end ready=%0b busy=%0b want 0 1", pix_ready, busy);
    end
    n_tests++;
    if (wr_count != NPIX || wq.size() != 0) begin
      n_fail++;
      $display("FAIL load_writes got=%0d want=%0d", wr_count, NPIX);
    end
    repeat (6) tick();
    n_tests++;
    if (tv_count != 0 || pix_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_no_conv taps=%0d ready=%0b want 0 0",
               tv_count, pix_ready);
    end
  endtask

  task automatic test_scan();
    conv_ready = 1'b1;
    wait_done(1, 300);
    n_tests++;
    if (tv_count != NTAP || tv_cyc[NTAP-1] - tv_cyc[0] != NTAP - 1) begin
      n_fail++;
      $display("FAIL scan_contig got=%0d span=%0d want %0d %0d",
               tv_count, tv_cyc[tv_count-1] - tv_cyc[0], NTAP, NTAP - 1);
    end
    n_tests++;
    if (last_data !== pix_m[NPIX-1]) begin
      n_fail++;
      $display("FAIL last_data got=%0d want=%0d", last_data, pix_m[NPIX-1]);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || pix_ready !== 1'b1 || done_count != 1) begin
      n_fail++;
      $display("FAIL after_flush busy=%0b ready=%0b done=%0d want 0 1 1",
               busy, pix_ready, done_count);
    end
  endtask

  task automatic test_stall();
    clr_stats();
    conv_ready = 1'b0;
    feed_frame(1'b0, 1'b0);
    conv_ready = 1'b1;
    wait_taps(17, 200);
    conv_ready = 1'b0;
    repeat (4) tick();
    tick();
    conv_ready = 1'b1;
    wait_taps(20, 200);
    conv_ready = 1'b0;
    repeat (3) tick();
    conv_ready = 1'b1;
    wait_done(1, 300);
    n_tests++;
    if (tv_count != NTAP || tv_cyc[18] - tv_cyc[17] != 5) begin
      n_fail++;
      $display("FAIL stall_gap got=%0d want=5", tv_cyc[18] - tv_cyc[17]);
    end
    n_tests++;
    if (tv_cyc[26] - tv_cyc[18] != 8) begin
      n_fail++;
      $display("FAIL window_split got=%0d want=8", tv_cyc[26] - tv_cyc[18]);
    end
  endtask

  task automatic test_reset_mid();
    clr_stats();
    conv_ready = 1'b0;
    feed_frame(1'b0, 1'b0);
    conv_ready = 1'b1;
    wait_taps(47, 200);
    rst = 1'b1;
    tq.delete();
    wq.delete();
    tick();
    n_tests++;
    if ({tap_valid, pix_ready, busy, frame_done, mem_we} !== 5'b01000) begin
      n_fail++;
      $display("FAIL mid_reset got=%b want=01000",
               {tap_valid, pix_ready, busy, frame_done, mem_we});
    end
    rst = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (done_count != 0) begin
      n_fail++;
      $display("FAIL mid_reset_done got=%0d want=0", done_count);
    end
    clr_stats();
    feed_frame(1'b0, 1'b0);
    wait_done(1, 300);
    n_tests++;
    if (tv_count != NTAP) begin
      n_fail++;
      $display("FAIL fresh_frame taps=%0d want=%0d", tv_count, NTAP);
    end
  endtask

  task automatic test_back_to_back();
    repeat (2) tick();
    clr_stats();
    conv_ready = 1'b1;
    feed_frame(1'b1, 1'b0);
    feed_frame(1'b0, 1'b1);
    wait_done(2, 300);
    n_tests++;
    if (tv_count != 2 * NTAP || wr_count != 2 * NPIX) begin
      n_fail++;
      $display("FAIL b2b taps=%0d writes=%0d want %0d %0d",
               tv_count, wr_count, 2 * NTAP, 2 * NPIX);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_scan();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
